float_accum: RTL and testbench
==============================

Name: float_accum

Overview:
- Multi-cycle IEEE-754-style floating-point accumulator placed directly downstream of the floating-point multiplier, in the IIR datapath.
- Sums a burst of multiplier products (first..last) into one running value and emits the sum with a sticky exception flag.
- Uses the same parameterised float format as the multiplier: sign | exponent | mantissa, hidden 1, bias 2^(WIDTH_exp-1)-1.
- An all-zero word is 0.0; exponent field 0 is treated as zero (no denormals).

Parameters:
- WIDTH, 32, total float width (must equal 1+WIDTH_exp+WIDTH_mat)
- WIDTH_exp, 8, exponent field width
- WIDTH_mat, 23, mantissa field width (hidden bit excluded)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  OP/first/last/exce_in are valid this cycle
- in_ready  out  1  accumulator can accept an operand this cycle
- OP  in  WIDTH  operand (multiplier result)
- first  in  1  operand starts a new sum (added to 0, not to acc)
- last  in  1  operand ends the sum; completion produces out_valid
- exce_in  in  1  exception from upstream multiplier for this operand
- result  out  WIDTH  accumulated sum, held until the next completed sum
- out_valid  out  1  one-cycle pulse: result/exce_out are new
- exce_out  out  1  sticky OR of exce_in and overflow over the current sum

Behaviour:
- Reset (nRST=0, async): state=IDLE; acc=0; exc sticky=0; result=0; out_valid=0; exce_out=0; in_ready=1 once nRST=1.
- Reset mid-operation aborts the operand in flight; no out_valid is produced for it.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch OP, first, last and exce_in, then go to ALIGN. Addend A is 0 if first=1, else acc.
  - ALIGN: in_ready=0. Order |A| and |OP| by exponent, then mantissa; the larger becomes X. Shift the smaller mantissa (hidden bit restored) right by the exponent difference. A difference > WIDTH_mat+1 makes the smaller term 0. A zero operand contributes 0. Go to ADD.
  - ADD: WIDTH_mat+2-bit magnitude add when signs are equal, otherwise larger minus smaller. Result sign = sign of X. Go to NORM.
  - NORM: carry out -> shift right 1, exponent+1. Otherwise a one-cycle leading-zero count -> shift left by lz, exponent-lz. Then go to IDLE.
- NORM result rules:
  - Zero magnitude -> all-zero word (+0.0).
  - Exponent <=0 -> flush to +0.0; no exception.
  - Exponent >= 2^WIDTH_exp-1 -> saturate to sign|all-ones exponent|zero mantissa, and set the sticky exception.
  - Rounding is truncation.
- Sticky exception: cleared when an operand with first=1 is accepted; ORed with exce_in on every accept.
- Handshake: an operand is accepted when in_valid=1 and in_ready=1. Throughput is 1 operand per 4 cycles. Accepted at edge k -> acc updated at edge k+3 -> in_ready=1 again in cycle k+3.
- Completion: when last=1, at edge k+3 the block loads result=acc_new and exce_out=sticky, and pulses out_valid=1 for exactly one cycle.
- first=1 and last=1 on the same operand: result = normalised OP (+0.0 for zero input).
- in_valid while in_ready=0: ignored; the upstream holds the operand.

Decomposition:
- Shared package float_pkg:
  - WIDTH/WIDTH_exp/WIDTH_mat defaults
  - BIAS constant
  - field-slice helpers
  - FSM state encoding (IDLE, ALIGN, ADD, NORM)
- One natural sub-module: float_lzc (combinational leading-zero counter, WIDTH_mat+2 bits in, count out), used by NORM.

Test Plan:
- first=1,last=0 OP=0x3FC00000 (1.5); then first=0,last=1 OP=0x40200000 (2.5) -> after second accept+3 cycles: out_valid pulse, result=0x40800000 (4.0), exce_out=0.
- first=1 OP=0x3F800000; last=1 OP=0xBF800000 -> result=0x00000000, exce_out=0.
- first=1 OP=0x3F800000; last=1 OP=0x30800000 (2^-30, exp diff 30) -> result=0x3F800000.
- first=1 OP=0x7F000000; last=1 OP=0x7F000000 -> result=0x7F800000, exce_out=1. A following burst 0x3F800000 (first=1,last=1) -> exce_out=0, result=0x3F800000.
- first=1,last=1 OP=0x40000000 with exce_in=1 -> result=0x40000000, exce_out=1.
- Handshake/reset: hold in_valid=1 continuously -> in_ready high 1 cycle in every 4 and each operand accepted exactly once. Drop nRST in the ADD cycle -> all outputs 0 at once, no out_valid pulse, next burst correct.

Source files
------------

// File: rtl/float_pkg.sv
// float_pkg -- shared definitions for the IIR floating-point datapath.
//
// Purpose : default float format (sign | exponent | mantissa, hidden 1),
//           exponent bias, field-slice helpers for the default format and
//           the accumulator FSM state encoding.
// Ports   : none (package).
package float_pkg;

   localparam int FP_WIDTH     = 32;
   localparam int FP_WIDTH_EXP = 8;
   localparam int FP_WIDTH_MAT = 23;
   localparam int FP_BIAS      = (1 << (FP_WIDTH_EXP - 1)) - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_ADD   = 2'd2,
      S_NORM  = 2'd3
   } acc_state_t;

   function automatic logic fp_sign(input logic [FP_WIDTH-1:0] w);
      return w[FP_WIDTH-1];
   endfunction

   function automatic logic [FP_WIDTH_EXP-1:0] fp_exp(input logic [FP_WIDTH-1:0] w);
      return w[FP_WIDTH-2 -: FP_WIDTH_EXP];
   endfunction

   function automatic logic [FP_WIDTH_MAT-1:0] fp_mant(input logic [FP_WIDTH-1:0] w);
      return w[FP_WIDTH_MAT-1:0];
   endfunction

endpackage

// File: rtl/float_lzc.sv
// float_lzc -- combinational leading-zero counter.
//
// Purpose : counts the zeros above the most significant set bit of din.
//           An all-zero input returns W.
// Ports   : din   [W-1:0]     value to scan (MSB first)
//           count [CNT_W-1:0] number of leading zeros
module float_lzc #(
   parameter int W     = 25,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     din,
   output logic [CNT_W-1:0] count
);

   // Scan upwards; the highest set bit is the last one to assign.
   always_comb begin
      count = CNT_W'(W);
      for (int i = 0; i < W; i++) begin
         if (din[i]) begin
            count = CNT_W'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/float_accum.sv
// float_accum -- multi-cycle floating-point burst accumulator.
//
// Purpose : sums a burst of multiplier products (first..last) into one
//           running value using a 4-state FSM (IDLE, ALIGN, ADD, NORM),
//           one operand every 4 cycles. Truncating arithmetic, exponent
//           field 0 means zero, underflow flushes to +0.0, overflow
//           saturates and raises a sticky exception.
// Ports   : CLK        clock, rising edge
//           nRST       asynchronous active-low reset
//           in_valid   operand/first/last/exce_in valid
//           in_ready   operand can be accepted this cycle
//           OP         operand word
//           first      operand starts a new sum
//           last       operand ends the sum
//           exce_in    upstream exception for this operand
//           result     last completed sum (held)
//           out_valid  one-cycle pulse when result/exce_out update
//           exce_out   sticky exception of the completed sum
module float_accum
   import float_pkg::*;
#(
   parameter int WIDTH     = FP_WIDTH,
   parameter int WIDTH_exp = FP_WIDTH_EXP,
   parameter int WIDTH_mat = FP_WIDTH_MAT
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] OP,
   input  logic             first,
   input  logic             last,
   input  logic             exce_in,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             exce_out
);

   localparam int SIG_W = WIDTH_mat + 1;   // significand with hidden bit
   localparam int SUM_W = WIDTH_mat + 2;   // plus carry slot
   localparam int LZ_W  = $clog2(SUM_W + 1);
   localparam int EXP_W = WIDTH_exp + 2;   // signed, room for under/overflow
   localparam logic [WIDTH_exp-1:0]        EXP_ONES  = '1;
   localparam logic [WIDTH_exp-1:0]        MAX_SHIFT = WIDTH_exp'(SIG_W);
   localparam logic signed [EXP_W-1:0]     EXP_SAT   = $signed({2'b00, EXP_ONES});

   acc_state_t           state_reg;
   logic [WIDTH-1:0]     acc_reg;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     op_reg;
   logic                 last_reg;
   logic                 sticky_reg;
   logic                 x_sign_reg;
   logic                 sub_reg;
   logic [WIDTH_exp-1:0] x_exp_reg;
   logic [SIG_W-1:0]     mx_reg;
   logic [SIG_W-1:0]     my_reg;
   logic [SUM_W-1:0]     sum_reg;

   // Reset must drop in_ready immediately, hence the nRST term.
   assign in_ready = nRST && (state_reg == S_IDLE);

   // ---------------- ALIGN: order magnitudes, align the smaller ----------
   logic [WIDTH-2:0]     a_mag, op_mag, x_mag, y_mag;
   logic                 x_sign, y_sign;
   logic [WIDTH_exp-1:0] x_exp, y_exp, exp_diff;
   logic [SIG_W-1:0]     x_sig, y_sig, y_aligned;

   always_comb begin
      // A word with exponent 0 is zero regardless of its mantissa bits.
      a_mag  = (a_reg[WIDTH-2 -: WIDTH_exp] == '0) ? '0 : a_reg[WIDTH-2:0];
      op_mag = (op_reg[WIDTH-2 -: WIDTH_exp] == '0) ? '0 : op_reg[WIDTH-2:0];
      // {exponent, mantissa} compares as an unsigned magnitude.
      if (op_mag > a_mag) begin
         x_mag  = op_mag;
         y_mag  = a_mag;
         x_sign = op_reg[WIDTH-1];
         y_sign = a_reg[WIDTH-1];
      end else begin
         x_mag  = a_mag;
         y_mag  = op_mag;
         x_sign = a_reg[WIDTH-1];
         y_sign = op_reg[WIDTH-1];
      end
      x_exp     = x_mag[WIDTH-2 -: WIDTH_exp];
      y_exp     = y_mag[WIDTH-2 -: WIDTH_exp];
      exp_diff  = x_exp - y_exp;
      x_sig     = (x_mag == '0) ? '0 : {1'b1, x_mag[WIDTH_mat-1:0]};
      y_sig     = (y_mag == '0) ? '0 : {1'b1, y_mag[WIDTH_mat-1:0]};
      y_aligned = (exp_diff > MAX_SHIFT) ? '0 : (y_sig >> exp_diff);
   end

   // ---------------- ADD: magnitude add / subtract ----------------------
   // X >= Y in magnitude, so the subtraction never goes negative.
   logic [SUM_W-1:0] sum_next;
   always_comb begin
      if (sub_reg) begin
         sum_next = {1'b0, mx_reg} - {1'b0, my_reg};
      end else begin
         sum_next = {1'b0, mx_reg} + {1'b0, my_reg};
      end
   end

   // ---------------- NORM: normalise, flush, saturate -------------------
   logic [LZ_W-1:0]         lz;
   logic [SUM_W-1:0]        norm_shift;
   logic signed [EXP_W-1:0] norm_exp;
   logic [WIDTH-1:0]        norm_word;
   logic                    norm_ovf;

   float_lzc #(
      .W     (SUM_W),
      .CNT_W (LZ_W)
   ) u_lzc (
      .din   (sum_reg),
      .count (lz)
   );

   // Shifting by lz puts the leading one in the carry slot; the carry case
   // is lz=0, so one formula covers both the right and left adjustments:
   // exponent = x_exp + 1 - lz, mantissa = the bits just below the top.
   always_comb begin
      norm_shift = sum_reg << lz;
      norm_exp   = $signed({2'b00, x_exp_reg}) + $signed(EXP_W'(1))
                   - $signed(EXP_W'(lz));
      norm_word  = '0;
      norm_ovf   = 1'b0;
      if (sum_reg == '0 || norm_exp <= 0) begin
         norm_word = '0;
      end else if (norm_exp >= EXP_SAT) begin
         norm_word = {x_sign_reg, EXP_ONES, {WIDTH_mat{1'b0}}};
         norm_ovf  = 1'b1;
      end else begin
         norm_word = {x_sign_reg, norm_exp[WIDTH_exp-1:0], WIDTH_mat'(norm_shift >> 1)};
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg  <= S_IDLE;
         acc_reg    <= '0;
         a_reg      <= '0;
         op_reg     <= '0;
         last_reg   <= 1'b0;
         sticky_reg <= 1'b0;
         x_sign_reg <= 1'b0;
         sub_reg    <= 1'b0;
         x_exp_reg  <= '0;
         mx_reg     <= '0;
         my_reg     <= '0;
         sum_reg    <= '0;
         result     <= '0;
         out_valid  <= 1'b0;
         exce_out   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  op_reg     <= OP;
                  a_reg      <= first ? '0 : acc_reg;
                  last_reg   <= last;
                  sticky_reg <= (first ? 1'b0 : sticky_reg) | exce_in;
                  state_reg  <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               x_sign_reg <= x_sign;
               sub_reg    <= x_sign ^ y_sign;
               x_exp_reg  <= x_exp;
               mx_reg     <= x_sig;
               my_reg     <= y_aligned;
               state_reg  <= S_ADD;
            end
            S_ADD: begin
               sum_reg   <= sum_next;
               state_reg <= S_NORM;
            end
            S_NORM: begin
               acc_reg    <= norm_word;
               sticky_reg <= sticky_reg | norm_ovf;
               if (last_reg) begin
                  result    <= norm_word;
                  exce_out  <= sticky_reg | norm_ovf;
                  out_valid <= 1'b1;
               end
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_accum.sv
// tb_float_accum -- self-checking bench for float_accum.
//
// Purpose : directed bursts with literal expectations plus randomized
//           bursts; a behavioural model predicts every output each cycle.
// Ports   : none (top-level bench).
module tb_float_accum;
   import float_pkg::*;

   logic        CLK;
   logic        nRST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] OP;
   logic        first;
   logic        last;
   logic        exce_in;
   logic [31:0] result;
   logic        out_valid;
   logic        exce_out;

   int vectors     = 0;
   int miscompares = 0;

   float_accum dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .OP        (OP),
      .first     (first),
      .last      (last),
      .exce_in   (exce_in),
      .result    (result),
      .out_valid (out_valid),
      .exce_out  (exce_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: real-valued add with the block's alignment rule (smaller
   // term truncated to the significand grid before combining), truncating
   // normalisation, flush below exponent 1, saturation at exponent 255.
   // Returns {overflow, word}.
   function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
      longint ma, mb, sx, sy, m;
      int ex, ey, e, d;
      logic [31:0] x, y;
      ma = (fp_exp(a) == 0) ? 0 : longint'(a[30:0]);
      mb = (fp_exp(b) == 0) ? 0 : longint'(b[30:0]);
      if (ma == 0 && mb == 0) return 33'h0;
      if (mb > ma) begin x = b; y = a; end
      else begin x = a; y = b; end
      ex = int'(fp_exp(x));
      ey = (fp_exp(y) == 0) ? 0 : int'(fp_exp(y));
      sx = longint'((1 << 23) | int'(fp_mant(x)));
      d  = ex - ey;
      if (ey == 0 || d > 24) sy = 0;
      else sy = longint'((1 << 23) | int'(fp_mant(y))) >> d;
      m = (fp_sign(x) == fp_sign(y)) ? sx + sy : sx - sy;
      if (m == 0) return 33'h0;
      e = ex;
      while (m >= (longint'(1) << 24)) begin m = m >> 1; e++; end
      while (m <  (longint'(1) << 23)) begin m = m << 1; e--; end
      if (e <= 0) return 33'h0;
      if (e >= 255) return {1'b1, fp_sign(x), 8'hFF, 23'h0};
      return {1'b0, fp_sign(x), 8'(e), 23'(m)};
   endfunction

   // ---------------- model state and per-cycle compare ----------------
   logic [31:0] m_acc, m_result, p_acc;
   logic        m_sticky, m_exce, p_sticky, p_last, p_valid;
   logic [32:0] m_sum;
   logic        exp_ov;
   int          cyc = 0, p_due = 0, accepts = 0, pulses = 0;

   always @(negedge CLK) begin
      cyc++;
      if (out_valid) pulses++;
      if (!nRST) begin
         m_acc = 0; m_result = 0; m_sticky = 0; m_exce = 0; p_valid = 0;
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_result", 64'(result), 64'd0);
         chk("rst_exce_out", 64'(exce_out), 64'd0);
      end else begin
         exp_ov = 1'b0;
         if (p_valid && cyc == p_due) begin
            m_acc    = p_acc;
            m_sticky = p_sticky;
            if (p_last) begin
               m_result = p_acc;
               m_exce   = p_sticky;
               exp_ov   = 1'b1;
            end
            p_valid = 1'b0;
         end
         chk("in_ready", 64'(in_ready), 64'(!p_valid));
         chk("out_valid", 64'(out_valid), 64'(exp_ov));
         chk("result", 64'(result), 64'(m_result));
         chk("exce_out", 64'(exce_out), 64'(m_exce));
         if (in_valid && !p_valid) begin
            m_sum    = model_add(first ? 32'h0 : m_acc, OP);
            p_acc    = m_sum[31:0];
            p_sticky = (first ? 1'b0 : m_sticky) | exce_in | m_sum[32];
            p_last   = last;
            p_due    = cyc + 4;
            p_valid  = 1'b1;
            accepts++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] op, input logic f, input logic l, input logic e);
      bit got;
      got = 0;
      OP = op; first = f; last = l; exce_in = e; in_valid = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge CLK);
         if (in_ready) got = 1;
         @(posedge CLK);
         #1;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: operand %h not accepted within 40 cycles", op);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic burst2(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input string name);
      send(a, 1'b1, 1'b0, 1'b0);
      send(b, 1'b0, 1'b1, 1'b0);
      idle(5);
      chk({name, "_result"}, 64'(result), 64'(exp_res));
      chk({name, "_exce"}, 64'(exce_out), 64'(exp_exc));
   endtask

   function automatic logic [31:0] rand_op();
      int k;
      logic [7:0] e;
      logic s;
      k = $urandom_range(0, 15);
      s = 1'($urandom_range(0, 1));
      if (k == 0) return 32'h0;
      if (k == 1) e = 8'($urandom_range(250, 254));
      else if (k == 2) e = 8'($urandom_range(1, 4));
      else e = 8'(FP_BIAS - 7 + int'($urandom_range(0, 14)));
      return {s, e, 23'($urandom)};
   endfunction

   int a0, pl0, len;

   initial begin
      nRST = 1'b0; in_valid = 1'b0; OP = 0; first = 0; last = 0; exce_in = 0;
      repeat (2) @(posedge CLK);
      #3 nRST = 1'b1;
      @(negedge CLK);
      chk("post_reset_ready", 64'(in_ready), 64'd1);
      chk("post_reset_result", 64'(result), 64'd0);

      // Pin the model with hand-computed values.
      chk("model_1p5_2p5", 64'(model_add(32'h3FC00000, 32'h40200000)), 64'h0_40800000);
      chk("model_ovf", 64'(model_add(32'h7F000000, 32'h7F000000)), 64'h1_7F800000);
      chk("model_tiny", 64'(model_add(32'h3F800000, 32'h30800000)), 64'h0_3F800000);

      @(posedge CLK); #1;
      burst2(32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, "sum_4p0");
      burst2(32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, "cancel");
      burst2(32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, "tiny");
      burst2(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, "overflow");
      send(32'h3F800000, 1'b1, 1'b1, 1'b0);
      idle(5);
      chk("sticky_clear_result", 64'(result), 64'h3F800000);
      chk("sticky_clear_exce", 64'(exce_out), 64'd0);
      send(32'h40000000, 1'b1, 1'b1, 1'b1);
      idle(5);
      chk("exce_in_result", 64'(result), 64'h40000000);
      chk("exce_in_exce", 64'(exce_out), 64'd1);

      // Back-to-back: in_valid held high for the whole burst.
      a0 = accepts; pl0 = pulses;
      for (int i = 0; i < 8; i++) send(32'h3F800000, i == 0, i == 7, 1'b0);
      idle(5);
      chk("b2b_accepts", 64'(accepts - a0), 64'd8);
      chk("b2b_pulses", 64'(pulses - pl0), 64'd1);
      chk("b2b_result", 64'(result), 64'h41000000);

      // Reset during the ADD cycle of a single-operand sum.
      send(32'h40400000, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      @(posedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_ready", 64'(in_ready), 64'd0);
      pl0 = pulses;
      @(posedge CLK);
      #3 nRST = 1'b1;
      idle(6);
      chk("abort_no_pulse", 64'(pulses - pl0), 64'd0);
      burst2(32'h40400000, 32'h3F800000, 32'h40800000, 1'b0, "after_abort");

      // Randomized bursts, checked every cycle by the model.
      for (int b = 0; b < 150; b++) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            send(rand_op(), i == 0, i == len - 1, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
         idle($urandom_range(0, 2));
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
